// File: rtl/edge_det_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// edge_det_pkg : shared types and helpers for edge_detector_array.
// Optional input synchroniser is enabled by defining EDGE_DET_SYNC_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
package edge_det_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

`ifdef EDGE_DET_SYNC_EN
  localparam bit SYNC_EN = 1'b1;
`else
  localparam bit SYNC_EN = 1'b0;
`endif

  // Counter must hold 0..FILTER_CYCLES-1; never narrower than one bit.
  function automatic int unsigned filter_cnt_width(input int unsigned filter_cycles);
    int unsigned w;
    w = $clog2(filter_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic mode_event(input edge_mode_e mode,
                                      input logic       rise,
                                      input logic       fall);
    logic ev;
    case (mode)
      EDGE_OFF:  ev = 1'b0;
      EDGE_RISE: ev = rise;
      EDGE_FALL: ev = fall;
      EDGE_BOTH: ev = rise | fall;
      default:   ev = 1'b0;
    endcase
    return ev;
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_det_channel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// edge_det_channel : one-bit synchroniser (EDGE_DET_SYNC_EN), glitch filter,
// filtered level and registered rise/fall pulses.
// Revision: 1.0
// ---------------------------------------------------------------------------
module edge_det_channel
  import edge_det_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 3,
  parameter logic        INIT_LEVEL    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned     SYNC_DEPTH = SYNC_EN ? SYNC_STAGES : 0;
  localparam int unsigned     CNT_W      = filter_cnt_width(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FILTER_CYCLES - 1);

  logic             s;
  logic [CNT_W-1:0] cnt;

  if (SYNC_DEPTH > 0) begin : g_sync
    logic [SYNC_DEPTH-1:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_q <= {SYNC_DEPTH{INIT_LEVEL}};
      end else begin
        sync_q <= {sync_q[SYNC_DEPTH-2:0], din};
      end
    end

    assign s = sync_q[SYNC_DEPTH-1];
  end else begin : g_nosync
    assign s = din;
  end

  // A new level is accepted only after FILTER_CYCLES consecutive mismatches;
  // any return to the accepted level restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level <= INIT_LEVEL;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= s;
        cnt   <= '0;
        rise  <= s;
        fall  <= ~s;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/edge_detector_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// edge_detector_array : NUM_CH filtered edge detectors with per-channel mode
// masking, sticky pending flags and an aggregated interrupt.
// Synchroniser stages are present only when EDGE_DET_SYNC_EN is defined.
// Revision: 1.0
// ---------------------------------------------------------------------------
module edge_detector_array
  import edge_det_pkg::*;
#(
  parameter int unsigned        NUM_CH        = 4,
  parameter int unsigned        SYNC_STAGES   = 2,
  parameter int unsigned        FILTER_CYCLES = 3,
  parameter logic [NUM_CH-1:0]  INIT_LEVEL    = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   a_i,
  input  logic [2*NUM_CH-1:0] mode_i,
  input  logic [NUM_CH-1:0]   clear_i,
  output logic [NUM_CH-1:0]   level_o,
  output logic [NUM_CH-1:0]   rising_edge_o,
  output logic [NUM_CH-1:0]   falling_edge_o,
  output logic [NUM_CH-1:0]   event_o,
  output logic [NUM_CH-1:0]   pending_o,
  output logic                irq_o
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    edge_det_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES),
      .INIT_LEVEL    (INIT_LEVEL[i])
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .din   (a_i[i]),
      .level (level_o[i]),
      .rise  (rising_edge_o[i]),
      .fall  (falling_edge_o[i])
    );

    // Mode is applied combinationally so a mode change never disturbs pending.
    assign event_o[i] = mode_event(edge_mode_e'(mode_i[2*i +: 2]),
                                   rising_edge_o[i], falling_edge_o[i]);
  end

  // Set wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_o <= '0;
    end else begin
      pending_o <= (pending_o & ~clear_i) | event_o;
    end
  end

  assign irq_o = |pending_o;

endmodule
`default_nettype wire

// File: tb/tb_edge_detector_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_edge_detector_array : directed self-checking bench for edge_detector_array.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_edge_detector_array;

  localparam int NCH = 4;
  localparam int FC  = 3;
`ifdef EDGE_DET_SYNC_EN
  localparam int LAT = 2 + FC;
`else
  localparam int LAT = FC;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NCH-1:0] a_i = '0;
  logic [2*NCH-1:0] mode_i = '0;
  logic [NCH-1:0] clear_i = '0;
  logic [NCH-1:0] level_o, rising_edge_o, falling_edge_o, event_o, pending_o;
  logic           irq_o;

  int checks = 0;
  int errors = 0;
  int rise_cnt[NCH];
  int fall_cnt[NCH];
  int ev_cnt[NCH];

  edge_detector_array #(
    .NUM_CH        (NCH),
    .SYNC_STAGES   (2),
    .FILTER_CYCLES (FC),
    .INIT_LEVEL    (4'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .a_i            (a_i),
    .mode_i         (mode_i),
    .clear_i        (clear_i),
    .level_o        (level_o),
    .rising_edge_o  (rising_edge_o),
    .falling_edge_o (falling_edge_o),
    .event_o        (event_o),
    .pending_o      (pending_o),
    .irq_o          (irq_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NCH; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
      ev_cnt[i]   = 0;
    end
  endtask

  task automatic run_count(input int n);
    repeat (n) begin
      step();
      for (int i = 0; i < NCH; i++) begin
        rise_cnt[i] += int'(rising_edge_o[i]);
        fall_cnt[i] += int'(falling_edge_o[i]);
        ev_cnt[i]   += int'(event_o[i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int exp_ev[NCH];
    exp_ev = '{0, 1, 1, 2};

    // Reset held with all inputs high
    a_i = 4'hF;
    #1 reset = 1'b0;
    step(3);
    check_val("rst_level",   level_o,        4'h0);
    check_val("rst_rise",    rising_edge_o,  4'h0);
    check_val("rst_fall",    falling_edge_o, 4'h0);
    check_val("rst_event",   event_o,        4'h0);
    check_val("rst_pending", pending_o,      4'h0);
    check_val("rst_irq",     irq_o,          1'b0);

    // Release: inputs differ from INIT_LEVEL -> one rise after full latency
    reset = 1'b1;
    step(LAT - 1);
    check_val("rel_rise_early", rising_edge_o, 4'h0);
    check_val("rel_level_early", level_o, 4'h0);
    step();
    check_val("rel_rise", rising_edge_o, 4'hF);
    check_val("rel_level", level_o, 4'hF);
    check_val("rel_event_off", event_o, 4'h0);
    step();
    check_val("rel_rise_end", rising_edge_o, 4'h0);
    check_val("rel_pending_off", pending_o, 4'h0);
    a_i = 4'h0;
    step(LAT + 2);
    check_val("settle_low", level_o, 4'h0);

    // Single edges on ch0 with all channels in EDGE_BOTH
    mode_i = 8'hFF;
    a_i = 4'h1;
    step(LAT - 1);
    check_val("ch0_rise_early", rising_edge_o, 4'h0);
    step();
    check_val("ch0_rise", rising_edge_o, 4'h1);
    check_val("ch0_level", level_o, 4'h1);
    check_val("ch0_event", event_o, 4'h1);
    check_val("ch0_pending_lag", pending_o, 4'h0);
    step();
    check_val("ch0_rise_end", rising_edge_o, 4'h0);
    check_val("ch0_pending", pending_o, 4'h1);
    check_val("ch0_irq", irq_o, 1'b1);
    step(7);
    a_i = 4'h0;
    step(LAT);
    check_val("ch0_fall", falling_edge_o, 4'h1);
    check_val("ch0_level_low", level_o, 4'h0);
    check_val("ch0_fall_event", event_o, 4'h1);
    step();
    check_val("ch0_fall_end", falling_edge_o, 4'h0);
    check_val("ch0_pending_hold", pending_o, 4'h1);
    clear_i = 4'hF;
    step();
    clear_i = 4'h0;
    check_val("clr_pending", pending_o, 4'h0);
    check_val("clr_irq", irq_o, 1'b0);

    // Glitch on ch1: 2 cycles rejected, 3 cycles accepted
    clear_counts();
    a_i = 4'h2;
    run_count(2);
    a_i = 4'h0;
    run_count(8);
    check_val("glitch_rise", rise_cnt[1], 0);
    check_val("glitch_fall", fall_cnt[1], 0);
    check_val("glitch_level", level_o[1], 1'b0);
    clear_counts();
    a_i = 4'h2;
    run_count(3);
    a_i = 4'h0;
    run_count(LAT + 6);
    check_val("min_pulse_rise", rise_cnt[1], 1);
    check_val("min_pulse_fall", fall_cnt[1], 1);
    check_val("min_pulse_level", level_o[1], 1'b0);
    clear_i = 4'hF;
    step();
    clear_i = 4'h0;

    // Modes: ch0 OFF, ch1 RISE, ch2 FALL, ch3 BOTH
    mode_i = 8'hE4;
    clear_counts();
    a_i = 4'hF;
    run_count(LAT + 3);
    a_i = 4'h0;
    run_count(LAT + 3);
    for (int i = 0; i < NCH; i++) begin
      check_val($sformatf("mode_event_ch%0d", i), ev_cnt[i], exp_ev[i]);
      check_val($sformatf("mode_rise_ch%0d", i), rise_cnt[i], 1);
      check_val($sformatf("mode_fall_ch%0d", i), fall_cnt[i], 1);
    end
    check_val("mode_pending", pending_o, 4'hE);
    check_val("mode_irq", irq_o, 1'b1);

    // Pending: set wins over simultaneous clear, next clear takes effect
    clear_i = 4'hF;
    step();
    clear_i = 4'h0;
    mode_i = 8'hFF;
    a_i = 4'h4;
    step(LAT);
    check_val("pend_event", event_o, 4'h4);
    clear_i = 4'h4;
    step();
    check_val("pend_set_wins", pending_o, 4'h4);
    step();
    clear_i = 4'h0;
    check_val("pend_cleared", pending_o, 4'h0);
    check_val("pend_irq_low", irq_o, 1'b0);

    // Mode change leaves pending untouched
    a_i = 4'h0;
    step(LAT);
    check_val("pend_fall_event", event_o, 4'h4);
    step();
    check_val("pend_fall_set", pending_o, 4'h4);
    mode_i = 8'h00;
    step(2);
    check_val("pend_mode_change", pending_o, 4'h4);
    check_val("pend_mode_irq", irq_o, 1'b1);
    clear_i = 4'hF;
    step();
    clear_i = 4'h0;

    // Reset mid-filter: ch3 held high, ch0 filter partly advanced
    a_i = 4'h8;
    step(LAT + 2);
    check_val("pre_rst_level", level_o, 4'h8);
    a_i = 4'h9;
    step(LAT - 1);
    reset = 1'b0;
    #1;
    check_val("mid_rst_level", level_o, 4'h0);
    check_val("mid_rst_rise", rising_edge_o, 4'h0);
    check_val("mid_rst_pending", pending_o, 4'h0);
    step(2);
    reset = 1'b1;
    step(LAT - 1);
    check_val("post_rst_rise_early", rising_edge_o, 4'h0);
    check_val("post_rst_level_early", level_o, 4'h0);
    step();
    check_val("post_rst_rise", rising_edge_o, 4'h9);
    check_val("post_rst_level", level_o, 4'h9);
    step();
    check_val("post_rst_rise_end", rising_edge_o, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
